// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIXUP,
    DONE
  } div_state_e;

  localparam int DIV_W_MIN = 4;
  localparam int DIV_W_MAX = 64;

  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns WIDTH.
module div_lzc
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]            d_i,
  output logic [div_cnt_w(WIDTH)-1:0] cnt_o
);

  localparam int CW = div_cnt_w(WIDTH);

  // Scan upward so the highest set bit decides the count.
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (d_i[i]) cnt_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, signed/unsigned, divide-by-zero flag.
// DIV_EARLY_EXIT_EN skips the dividend's leading zeros to shorten latency.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 dbz_o
);

  localparam int CW = div_cnt_w(WIDTH);

  div_state_e         state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               rdy_q, rdy_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, a_shift;
  logic [CW-1:0]      steps;
  logic [WIDTH:0]     part, diff;
  logic               ge;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign a_mag = a_neg ? -opdata1_i : opdata1_i;
  assign b_mag = b_neg ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_EXIT_EN
  logic [CW-1:0] lz;

  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .d_i   (a_mag),
    .cnt_o (lz)
  );

  assign a_shift = a_mag << lz;
  assign steps   = (lz == CW'(WIDTH)) ? CW'(1) : CW'(WIDTH) - lz;
`else
  assign a_shift = a_mag;
  assign steps   = CW'(WIDTH);
`endif

  // Shift-then-subtract; the borrow bit of diff selects the quotient bit.
  assign part  = {rem_q, quo_q[WIDTH-1]};
  assign diff  = part - {1'b0, dvs_q};
  assign ge    = ~diff[WIDTH];
  assign q_fix = (s1_q ^ s2_q) ? -quo_q : quo_q;
  assign r_fix = s1_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    res_d   = res_q;
    rdy_d   = rdy_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            res_d   = {opdata1_i, {WIDTH{1'b1}}};
            rdy_d   = 1'b1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_shift;
            dvs_d   = b_mag;
            s1_d    = a_neg;
            s2_d    = b_neg;
            cnt_d   = steps;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = ge ? diff[WIDTH-1:0] : part[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        res_d   = {r_fix, q_fix};
        rdy_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!start_i) begin
          res_d   = '0;
          rdy_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (annul_i && state_q != IDLE) begin
      state_d = IDLE;
      res_d   = '0;
      rdy_d   = 1'b0;
      dbz_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
      dbz_q   <= dbz_d;
    end
  end

  assign result_o = res_q;
  assign ready_o  = rdy_q;
  assign dbz_o    = dbz_q;
  assign busy_o   = (state_q == BUSY) || (state_q == FIXUP);

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter with an arithmetic reference model.
module tb_div_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           signed_div_i = 1'b0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o, busy_o, dbz_o;

  int errors = 0;
  int checks = 0;

  logic         exp_act = 1'b0;
  logic [W-1:0] exp_q = '0;
  logic [W-1:0] exp_r = '0;
  logic         exp_dbz = 1'b0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .dbz_o        (dbz_o)
  );

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic s);
    exp_t   e;
    longint sa, sb, m;
    int     nb;
    e.dbz = (b == '0);
    if (e.dbz) begin
      e.q   = '1;
      e.r   = a;
      e.lat = 0;
      return e;
    end
    if (s) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
      m   = (sa < 0) ? -sa : sa;
    end else begin
      e.q = a / b;
      e.r = a % b;
      m   = longint'({32'b0, a});
    end
    nb = 1;
    for (int i = 0; i < W; i++)
      if ((m >> i) != 0) nb = i + 1;
`ifdef DIV_EARLY_EXIT_EN
    e.lat = nb + 1;
`else
    e.lat = W + 1;
`endif
    return e;
  endfunction

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Any cycle with ready_o high must carry the modelled result.
  always @(negedge clk) begin
    if (rst && ready_o) begin
      checks++;
      if (!exp_act) begin
        errors++;
        $display("FAIL unexpected_ready: result %0h dbz %0b",
                 result_o, dbz_o);
      end else if (result_o !== {exp_r, exp_q} || dbz_o !== exp_dbz) begin
        errors++;
        $display("FAIL result: got %0h dbz %0b expected %0h dbz %0b",
                 result_o, dbz_o, {exp_r, exp_q}, exp_dbz);
      end
    end
  end

  task automatic do_div(input vec_t v);
    exp_t e;
    int   k;
    e = model(v.a, v.b, v.s);
    check("model", {e.r, e.q, e.dbz}, {v.r, v.q, v.z});
    @(posedge clk);
    #1;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    signed_div_i = v.s;
    start_i      = 1'b1;
    exp_q        = e.q;
    exp_r        = e.r;
    exp_dbz      = e.dbz;
    exp_act      = 1'b1;
    @(posedge clk);
    k = -1;
    for (int c = 0; c <= W + 5; c++) begin
      @(negedge clk);
      if (ready_o) begin
        k = c;
        break;
      end
      check("busy", busy_o, 1'b1);
      if (c == 2) begin
        opdata1_i    = ~v.a;
        opdata2_i    = '0;
        signed_div_i = ~v.s;
      end
    end
    check("latency", k, e.lat);
    repeat (2) begin
      @(negedge clk);
      check("hold", ready_o, 1'b1);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("clear", {busy_o, ready_o, dbz_o, result_o}, '0);
    exp_act = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vq.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0});
    vq.push_back('{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
    vq.push_back('{32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0});
    vq.push_back('{32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1});
    vq.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0});
    vq.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0});
    vq.push_back('{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0});
    vq.push_back('{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0});
    vq.push_back('{32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1});
    vq.push_back('{32'd0, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0});
    vq.push_back('{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0});
    vq.push_back('{32'd3, 32'd1, 1'b0, 32'd3, 32'd0, 1'b0});

    #2;
    check("reset_out", {busy_o, ready_o, dbz_o, result_o}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (vq[i]) do_div(vq[i]);

    // Annul ten cycles into BUSY; no result may appear afterwards.
    @(posedge clk);
    #1;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    @(negedge clk);
    check("annul_idle", {busy_o, ready_o, result_o}, '0);
    repeat (40) @(negedge clk);
    check("annul_noready", ready_o, 1'b0);
    do_div('{32'd15, 32'd4, 1'b0, 32'd3, 32'd3, 1'b0});

    // Asynchronous reset in the middle of a division.
    @(posedge clk);
    #1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_busy", busy_o, 1'b1);
    rst = 1'b0;
    #1;
    check("async_reset", {busy_o, ready_o, dbz_o, result_o}, '0);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_div('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative radix-2 integer divider for the execute-stage multi-cycle unit, the successor of the fixed 32-bit divider. Width is a parameter. It handles signed and unsigned division, reports divide-by-zero explicitly, and can optionally skip the dividend's leading zeros to shorten latency. The result is held for the pipeline until the pipeline stops the request.

## Interface
- WIDTH, 32: operand width in bits; legal range 4..64.
- clk input 1: single clock, rising-edge.
- rst input 1: asynchronous, active-low reset.
- signed_div_i input 1: 1 = signed (two's complement) division; sampled with start_i.
- start_i input 1: request. Must stay high until the result has been consumed; dropping it releases the result.
- annul_i input 1: cancel. Overrides start_i in every state.
- opdata1_i input WIDTH: dividend; sampled on the accept edge.
- opdata2_i input WIDTH: divisor; sampled on the accept edge.
- result_o output 2*WIDTH: {remainder, quotient}.
- ready_o output 1: result_o is valid.
- busy_o output 1: high in BUSY and FIXUP.
- dbz_o output 1: divide-by-zero flag; valid while ready_o is high.

## Operation
- Reset values: state IDLE; result_o 0; ready_o, busy_o and dbz_o all 0; internal counter 0.
- States and transitions:
  - IDLE -> BUSY on start_i=1, annul_i=0 and divisor != 0. Both operand magnitudes and both sign bits are latched.
  - IDLE -> DONE on start_i=1, annul_i=0 and divisor == 0.
  - BUSY: one restoring step per cycle. Compute remainder minus divisor as a (WIDTH+1)-bit value. If it is non-negative, take the new remainder and shift in quotient bit 1; otherwise shift in 0.
  - BUSY -> FIXUP after the final step.
  - FIXUP: apply sign correction, write result_o, set ready_o=1, go to DONE.
  - DONE: hold result_o and ready_o. When start_i=0, go to IDLE and clear result_o, ready_o and dbz_o.
- Sign correction (signed mode only):
  - Quotient is negated when sign1 XOR sign2.
  - Remainder takes the dividend's sign.
  - Unsigned mode uses raw magnitudes.
- Divide-by-zero: quotient is all ones, remainder equals opdata1_i unmodified, dbz_o=1.
- Signed overflow (most-negative value / -1): quotient is the most-negative value, remainder is 0. No flag.
- Annul:
  - annul_i=1 in any non-IDLE state: next state IDLE, outputs cleared, the partial result is discarded.
  - annul_i=1 in IDLE blocks acceptance.
- start_i is ignored while busy; the latched operands are used.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately.

## Timing
- Normal latency: accept at edge 0, ready_o high after edge WIDTH+1 (33 cycles for WIDTH=32).
- Divide-by-zero: ready_o and dbz_o high after edge 0, i.e. 1 cycle.
- A new request can be accepted 1 cycle after start_i drops: DONE -> IDLE, then IDLE accepts.
- Annul in cycle k: busy_o is low after edge k.

## Configuration
- DIV_EARLY_EXIT_EN defined:
  - On accept, count the leading zeros lz of the dividend magnitude.
  - Pre-shift the dividend by lz.
  - Run max(WIDTH-lz, 1) BUSY steps. Latency becomes max(WIDTH-lz, 1)+1.
  - A zero dividend takes 1 step.
- DIV_EARLY_EXIT_EN undefined: always WIDTH steps and fixed latency. The leading-zero logic is not instantiated.

## Structure
- Shared package div_pkg holds:
  - the state enum typedef (IDLE, BUSY, FIXUP, DONE);
  - localparam helpers for counter width, $clog2(WIDTH+1).
- Sub-module div_lzc: parametrised leading-zero counter, WIDTH in, $clog2(WIDTH+1) out. Instantiated only under DIV_EARLY_EXIT_EN.

## Test plan
- Unsigned division, WIDTH=32, 100 / 7 -> quotient 14, remainder 2, dbz_o=0, ready_o high 33 cycles after accept (macro off).
- Signed division, 0xFFFFFFF9 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Same operands unsigned -> quotient 0x7FFFFFFC, remainder 1.
- Divide-by-zero, 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, dbz_o=1, ready_o high 1 cycle after accept. Dropping start_i clears all outputs next cycle.
- Signed overflow, 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Annul and reset:
  - annul_i pulsed at cycle 10 of BUSY -> ready_o never rises; the next request 15 / 4 returns quotient 3, remainder 3.
  - rst low mid-BUSY -> all outputs 0 immediately.
- Early exit with DIV_EARLY_EXIT_EN, 3 / 1 -> quotient 3, remainder 0, ready_o high 3 cycles after accept. A dividend of 0xFFFFFFFF still takes 33 cycles.
